// File: rtl/fp_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : fp_accumulator
// Description : Sequential binary32 accumulator. Sums N_TERMS products that
//               arrive over a valid/ready handshake using a multi-cycle
//               align/add/normalise FSM, then presents the sum on an output
//               handshake. No denormals, no NaN/Inf, truncation only.
//               Optional macro FP_ACC_RELU_EN clamps a negative final sum
//               to +0 on out_data.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_accumulator #(
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_COUNT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_last_term = CNT_W'(N_TERMS - 1);
    localparam logic [7:0]       c_mant_w    = 8'd24;

    state_t           r_state;
    state_t           w_state_next;

    logic [31:0]      r_acc;
    logic [31:0]      r_b;
    logic [31:0]      r_out_data;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_count;

    // Aligned operands handed from ALIGN to ADD
    logic             r_sign_a;
    logic             r_sign_b;
    logic [23:0]      r_mant_a;
    logic [23:0]      r_mant_b;
    logic [7:0]       r_exp;

    // Working value while normalising
    logic             r_norm_sign;
    logic [23:0]      r_norm_mant;
    logic [7:0]       r_norm_exp;

    // Alignment datapath
    logic             w_acc_zero;
    logic             w_b_zero;
    logic             w_a_exp_ge;
    logic [7:0]       w_exp_a;
    logic [7:0]       w_exp_b;
    logic [7:0]       w_exp_diff;
    logic [23:0]      w_full_a;
    logic [23:0]      w_full_b;
    logic [23:0]      w_small;
    logic [23:0]      w_small_shifted;

    // Add/subtract datapath
    logic [24:0]      w_sum;
    logic [23:0]      w_mag_diff;
    logic [23:0]      w_add_mant;
    logic [7:0]       w_add_exp;
    logic             w_add_sign;
    logic             w_add_zero;
    logic             w_mant_a_ge;

    logic             w_norm_flush;
    logic [31:0]      w_out_sum;

    // Align the smaller-exponent mantissa to the larger exponent (truncating)
    always_comb begin
        w_acc_zero      = (r_acc[30:0] == 31'd0);
        w_b_zero        = (r_b[30:0] == 31'd0);
        w_exp_a         = r_acc[30:23];
        w_exp_b         = r_b[30:23];
        w_full_a        = {1'b1, r_acc[22:0]};
        w_full_b        = {1'b1, r_b[22:0]};
        w_a_exp_ge      = (w_exp_a >= w_exp_b);
        w_exp_diff      = w_a_exp_ge ? (w_exp_a - w_exp_b) : (w_exp_b - w_exp_a);
        w_small         = w_a_exp_ge ? w_full_b : w_full_a;
        w_small_shifted = (w_exp_diff >= c_mant_w) ? 24'd0 : (w_small >> w_exp_diff);
    end

    // Sign-magnitude add of the aligned mantissas
    always_comb begin
        w_sum       = {1'b0, r_mant_a} + {1'b0, r_mant_b};
        w_mant_a_ge = (r_mant_a >= r_mant_b);
        w_mag_diff  = w_mant_a_ge ? (r_mant_a - r_mant_b) : (r_mant_b - r_mant_a);
        w_add_zero  = 1'b0;
        w_add_sign  = r_sign_a;
        w_add_mant  = w_sum[23:0];
        w_add_exp   = r_exp;
        if (r_sign_a == r_sign_b) begin
            if (w_sum[24]) begin
                w_add_mant = w_sum[24:1];
                w_add_exp  = r_exp + 8'd1;
            end
        end else begin
            w_add_mant = w_mag_diff;
            w_add_sign = w_mant_a_ge ? r_sign_a : r_sign_b;
            w_add_zero = (r_mant_a == r_mant_b);
        end
    end

    // A further left shift would push the exponent below 1: flush to +0
    assign w_norm_flush = !r_norm_mant[23] && (r_norm_exp <= 8'd1);

`ifdef FP_ACC_RELU_EN
    assign w_out_sum = (r_acc[31] && !w_acc_zero) ? 32'h0000_0000 : r_acc;
`else
    assign w_out_sum = r_acc;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and the input-side handshake
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (w_b_zero || w_acc_zero) begin
                    w_state_next = S_COUNT;
                end else begin
                    w_state_next = S_ADD;
                end
            end
            S_ADD: begin
                if (w_add_zero || w_add_mant[23]) begin
                    w_state_next = S_COUNT;
                end else begin
                    w_state_next = S_NORM;
                end
            end
            S_NORM: begin
                if (r_norm_mant[23] || w_norm_flush) begin
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (r_count == c_last_term) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers: operand capture, alignment, add, normalise, count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= 32'd0;
            r_b         <= 32'd0;
            r_out_data  <= 32'd0;
            r_out_valid <= 1'b0;
            r_count     <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_mant_a    <= 24'd0;
            r_mant_b    <= 24'd0;
            r_exp       <= 8'd0;
            r_norm_sign <= 1'b0;
            r_norm_mant <= 24'd0;
            r_norm_exp  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_b <= in_data;
                    end
                end
                S_ALIGN: begin
                    if (!w_b_zero) begin
                        if (w_acc_zero) begin
                            r_acc <= r_b;
                        end else begin
                            r_sign_a <= r_acc[31];
                            r_sign_b <= r_b[31];
                            r_mant_a <= w_a_exp_ge ? w_full_a : w_small_shifted;
                            r_mant_b <= w_a_exp_ge ? w_small_shifted : w_full_b;
                            r_exp    <= w_a_exp_ge ? w_exp_a : w_exp_b;
                        end
                    end
                end
                S_ADD: begin
                    if (w_add_zero) begin
                        r_acc <= 32'd0;
                    end else if (w_add_mant[23]) begin
                        r_acc <= {w_add_sign, w_add_exp, w_add_mant[22:0]};
                    end else begin
                        r_norm_sign <= w_add_sign;
                        r_norm_mant <= w_add_mant;
                        r_norm_exp  <= w_add_exp;
                    end
                end
                S_NORM: begin
                    if (r_norm_mant[23]) begin
                        r_acc <= {r_norm_sign, r_norm_exp, r_norm_mant[22:0]};
                    end else if (w_norm_flush) begin
                        r_acc <= 32'd0;
                    end else begin
                        r_norm_mant <= {r_norm_mant[22:0], 1'b0};
                        r_norm_exp  <= r_norm_exp - 8'd1;
                    end
                end
                S_COUNT: begin
                    if (r_count == c_last_term) begin
                        r_out_data  <= w_out_sum;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= 32'd0;
                        r_count     <= '0;
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fp_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_accumulator
// Description : Self-checking bench for fp_accumulator. A reference model
//               built on signed integer arithmetic predicts each sum; a
//               monitor compares every valid output cycle against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_accumulator;

    localparam int N_TERMS = 4;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int          checks;
    int          errors;
    int          n_accepted;
    int          n_target;
    int          rdy_mode;
    logic [31:0] last_acc;
    logic [31:0] q_expect[$];
    logic [31:0] m_acc;
    int          m_cnt;
    logic        prev_hold;

    fp_accumulator #(
        .N_TERMS (N_TERMS),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: value arithmetic on signed integers with truncating alignment
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        longint ma;
        longint mb;
        longint s;
        longint m;
        int     ea;
        int     eb;
        int     e;
        int     d;
        logic   neg;
        if (b[30:0] == 31'd0) return a;
        if (a[30:0] == 31'd0) return b;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = 0;
        mb = 0;
        ma[23:0] = {1'b1, a[22:0]};
        mb[23:0] = {1'b1, b[22:0]};
        if (ea >= eb) begin
            d  = ea - eb;
            e  = ea;
            mb = (d >= 24) ? 0 : (mb >> d);
        end else begin
            d  = eb - ea;
            e  = eb;
            ma = (d >= 24) ? 0 : (ma >> d);
        end
        if (a[31]) ma = -ma;
        if (b[31]) mb = -mb;
        s = ma + mb;
        if (s == 0) return 32'd0;
        neg = (s < 0);
        m   = neg ? -s : s;
        if (m >= 64'sd16777216) begin
            m = m >> 1;
            e = e + 1;
        end
        while (m < 64'sd8388608) begin
            m = m << 1;
            e = e - 1;
            if (e < 1) return 32'd0;
        end
        return {neg, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] model_out(input logic [31:0] s);
`ifdef FP_ACC_RELU_EN
        if (s[31] && (s[30:0] != 31'd0)) return 32'd0;
`endif
        return s;
    endfunction

    function automatic logic [31:0] rand_fp();
        int         k;
        logic [7:0] e;
        k = $urandom_range(0, 9);
        if (k == 0) return 32'd0;
        if (k == 1) e = 8'($urandom_range(1, 4));
        else        e = 8'($urandom_range(120, 135));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // Downstream ready policy: 0 always ready, 1 random, 2 held low
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: tracks accepted inputs in the model and checks every valid output cycle
    initial begin
        m_acc     = 32'd0;
        m_cnt     = 0;
        prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_acc = 32'd0;
                m_cnt = 0;
                q_expect.delete();
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    checks++;
                    if (!out_valid) begin
                        errors++;
                        $display("FAIL out_valid_hold: out_valid=%b required 1 until accepted", out_valid);
                    end
                end
                if (out_valid) begin
                    checks++;
                    if (q_expect.size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected: out_data=%h with no result pending", out_data);
                    end else if (out_data !== q_expect[0]) begin
                        errors++;
                        $display("FAIL out_data: got %h required %h", out_data, q_expect[0]);
                    end
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL in_ready_done: in_ready=%b required 0", in_ready);
                    end
                    if (out_ready && (q_expect.size() > 0)) begin
                        last_acc = out_data;
                        void'(q_expect.pop_front());
                        n_accepted++;
                    end
                end
                prev_hold = out_valid && !out_ready;
                if (in_valid && in_ready) begin
                    m_acc = model_add(m_acc, in_data);
                    m_cnt++;
                    if (m_cnt == N_TERMS) begin
                        q_expect.push_back(model_out(m_acc));
                        m_acc = 32'd0;
                        m_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] v, input int max_gap);
        int g;
        in_data  = v;
        in_valid = 1'b1;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        send(a, 1);
        send(b, 1);
        send(c, 1);
        send(d, 1);
        n_target++;
    endtask

    task automatic wait_results();
        int g;
        g = 0;
        while (n_accepted < n_target && g < 5000) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (n_accepted < n_target) begin
            errors++;
            $display("FAIL result_timeout: accepted %0d results, required %0d", n_accepted, n_target);
            n_accepted = n_target;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        n_accepted = 0;
        n_target   = 0;
        rdy_mode   = 0;
        last_acc   = 32'd0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 32'd0;

        // Pin the reference model against hand-computed sums
        check_lit("model_1234", model_add(model_add(model_add(32'h3F800000, 32'h40000000),
                                          32'h40400000), 32'h40800000), 32'h41200000);
        check_lit("model_cancel", model_add(32'h3FC00000, 32'hBFC00000), 32'h00000000);
        check_lit("model_norm", model_add(32'h3F800000, 32'hBF400000), 32'h3E800000);
        check_lit("model_trunc", model_add(32'h4B800000, 32'h3F800000), 32'h4B800000);
        check_lit("model_flush", model_add(32'h00C00000, 32'h80800000), 32'h00000000);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_lit("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check_lit("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_lit("reset_out_data", out_data, 32'd0);
        @(posedge clk);
        #1;

        // 1 + 2 + 3 + 4
        send4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        wait_results();
        check_lit("sum_1234", last_acc, 32'h41200000);

        // Exact cancellation, then zero operands
        send4(32'h3FC00000, 32'hBFC00000, 32'h00000000, 32'h00000000);
        wait_results();
        check_lit("sum_cancel", last_acc, 32'h00000000);

        // 1.0 - 0.75 needs normalisation
        send4(32'h3F800000, 32'hBF400000, 32'h00000000, 32'h00000000);
        wait_results();
        check_lit("sum_norm", last_acc, 32'h3E800000);

        // Underflow during normalisation flushes to +0
        send4(32'h00C00000, 32'h80800000, 32'h00000000, 32'h00000000);
        wait_results();
        check_lit("sum_flush", last_acc, 32'h00000000);

        // Truncation loses the small operand; output held while not ready
        rdy_mode = 2;
        send4(32'h4B800000, 32'h3F800000, 32'h00000000, 32'h00000000);
        begin
            int g;
            g = 0;
            while (!out_valid && g < 500) begin
                @(negedge clk);
                g++;
            end
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (!out_valid || in_ready || out_data !== 32'h4B800000) begin
                    errors++;
                    $display("FAIL hold_%0d: out_valid=%b in_ready=%b out_data=%h required 1 0 4b800000",
                             i, out_valid, in_ready, out_data);
                end
                @(negedge clk);
            end
        end
        rdy_mode = 0;
        wait_results();
        check_lit("sum_trunc", last_acc, 32'h4B800000);

        // Reset after two accepted terms discards the partial sum
        send(32'h40000000, 0);
        send(32'h40000000, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_lit("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_lit("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_lit("midrst_out_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        send4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        wait_results();
        check_lit("sum_after_rst", last_acc, 32'h40800000);

        // Negative final sum
        send4(32'hC0000000, 32'h00000000, 32'h00000000, 32'h00000000);
        wait_results();
`ifdef FP_ACC_RELU_EN
        check_lit("sum_negative", last_acc, 32'h00000000);
`else
        check_lit("sum_negative", last_acc, 32'hC0000000);
`endif

        // Randomised sums with random downstream back-pressure
        rdy_mode = 1;
        for (int n = 0; n < 12; n++) begin
            for (int t = 0; t < N_TERMS; t++) begin
                send(rand_fp(), 2);
            end
            n_target++;
        end
        wait_results();
        rdy_mode = 0;
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
